// File: rtl/dcache_data_ram_ctrl.sv
// rtl/dcache_data_ram_ctrl.sv - dcache data SRAM initiator: CPU load/store on port 0, line fill on port 1
// Every macro input is registered; load data is caught two cycles after accept into a small response FIFO.
module dcache_data_ram_ctrl #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 8,
   parameter int LINE_WORDS = 4,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     req_valid,
   output logic                                     req_ready,
   input  logic                                     req_we,
   input  logic [DATA_WIDTH/8-1:0]                  req_be,
   input  logic [ADDR_WIDTH-1:0]                    req_addr,
   input  logic [DATA_WIDTH-1:0]                    req_wdata,
   output logic                                     rsp_valid,
   input  logic                                     rsp_ready,
   output logic [DATA_WIDTH-1:0]                    rsp_rdata,
   input  logic                                     fill_start,
   input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] fill_line,
   input  logic                                     fill_valid,
   output logic                                     fill_ready,
   input  logic [DATA_WIDTH-1:0]                    fill_data,
   output logic                                     fill_busy,
   output logic                                     fill_done,
   output logic                                     csb0,
   output logic                                     web0,
   output logic [NUM_WMASKS-1:0]                    wmask0,
   output logic [ADDR_WIDTH-1:0]                    addr0,
   output logic [DATA_WIDTH-1:0]                    din0,
   input  logic [DATA_WIDTH-1:0]                    dout0,
   output logic                                     csb1,
   output logic                                     web1,
   output logic [NUM_WMASKS-1:0]                    wmask1,
   output logic [ADDR_WIDTH-1:0]                    addr1,
   output logic [DATA_WIDTH-1:0]                    din1
);
   localparam int BE_W        = DATA_WIDTH / 8;
   localparam int MASK_PER_BE = NUM_WMASKS / BE_W;
   localparam int OFF_W       = $clog2(LINE_WORDS);
   localparam int LINE_W      = ADDR_WIDTH - OFF_W;
   localparam int PTR_W       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int OCC_W       = $clog2(RSP_DEPTH + 3);

   typedef enum logic [1:0] {F_IDLE, F_FILL, F_DONE} fill_state_t;

   fill_state_t             fill_state_q, fill_state_d;
   logic [OFF_W-1:0]        beat_cnt;
   logic [LINE_W-1:0]       fill_line_q;
   logic                    beat_fire, last_beat, fill_go;
   logic                    req_fire, conflict, credit_ok, push, pop;
   logic                    rd_s1, rd_s2;
   logic [NUM_WMASKS-1:0]   be_mask;
   logic [OCC_W-1:0]        count, occupancy;
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];

   // Loads are charged against FIFO space from accept until pop, so a push can never overflow.
   assign occupancy = count + OCC_W'(rd_s1) + OCC_W'(rd_s2);
   assign credit_ok = occupancy < OCC_W'(RSP_DEPTH);
   assign conflict  = fill_busy && (req_addr[ADDR_WIDTH-1:OFF_W] == fill_line_q);
   assign req_ready = !conflict && (req_we || credit_ok);
   assign req_fire  = req_valid && req_ready;

   always_comb begin
      be_mask = '0;
      for (int i = 0; i < NUM_WMASKS; i++) be_mask[i] = req_be[i / MASK_PER_BE];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csb0   <= 1'b1;
         web0   <= 1'b1;
         wmask0 <= '0;
         addr0  <= '0;
         din0   <= '0;
         rd_s1  <= 1'b0;
         rd_s2  <= 1'b0;
      end else begin
         rd_s1 <= req_fire && !req_we;
         rd_s2 <= rd_s1;
         csb0  <= !(req_fire && (!req_we || req_be != '0));
         web0  <= !(req_fire && req_we && req_be != '0);
         if (req_fire) begin
            addr0 <= req_addr;
            din0  <= req_wdata;
            if (req_we) wmask0 <= be_mask;
         end
      end
   end

   // dout0 is valid at the second edge after accept: the macro captures on the first and reads on its negedge.
   assign push      = rd_s2;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_valid = (count != '0);
   assign rsp_rdata = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= dout0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign fill_go   = (fill_state_q == F_IDLE) && fill_start;
   assign beat_fire = fill_valid && fill_ready;
   assign last_beat = (beat_cnt == {OFF_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fill_state_q <= F_IDLE;
      else        fill_state_q <= fill_state_d;
   end

   always_comb begin
      fill_state_d = fill_state_q;
      case (fill_state_q)
         F_IDLE:  if (fill_start) fill_state_d = F_FILL;
         F_FILL:  if (beat_fire && last_beat) fill_state_d = F_DONE;
         F_DONE:  fill_state_d = F_IDLE;
         default: fill_state_d = F_IDLE;
      endcase
   end

   always_comb begin
      fill_ready = 1'b0;
      fill_busy  = 1'b0;
      fill_done  = 1'b0;
      case (fill_state_q)
         F_FILL:  begin fill_ready = 1'b1; fill_busy = 1'b1; end
         F_DONE:  begin fill_done  = 1'b1; fill_busy = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt    <= '0;
         fill_line_q <= '0;
         csb1        <= 1'b1;
         web1        <= 1'b1;
         wmask1      <= '0;
         addr1       <= '0;
         din1        <= '0;
      end else begin
         csb1 <= !beat_fire;
         web1 <= !beat_fire;
         if (fill_go) begin
            fill_line_q <= fill_line;
            beat_cnt    <= '0;
         end
         if (beat_fire) begin
            addr1    <= {fill_line_q, beat_cnt};
            din1     <= fill_data;
            wmask1   <= '1;
            beat_cnt <= beat_cnt + OFF_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_dcache_data_ram_ctrl.sv
// tb/tb_dcache_data_ram_ctrl.sv - bench for dcache_data_ram_ctrl with a behavioural SRAM macro
// Inputs driven 1ns after posedge, outputs read before the next edge; reference is a word array plus expected-response queue.
module tb_dcache_data_ram_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_be;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        fill_start, fill_valid, fill_ready, fill_busy, fill_done;
   logic [4:0]  fill_line;
   logic [31:0] fill_data;
   logic        csb0, web0, csb1, web1;
   logic [7:0]  wmask0, wmask1;
   logic [6:0]  addr0, addr1;
   logic [31:0] din0, din1, dout0;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] sram    [128] = '{default: 32'h0};
   logic [31:0] ref_mem [128] = '{default: 32'h0};

   logic        m_csb0 = 1'b1, m_web0 = 1'b1, m_csb1 = 1'b1, m_web1 = 1'b1;
   logic [7:0]  m_wm0 = 8'h0, m_wm1 = 8'h0;
   logic [6:0]  m_a0 = 7'h0, m_a1 = 7'h0;
   logic [31:0] m_d0 = 32'h0, m_d1 = 32'h0;

   always #5 clk = ~clk;

   dcache_data_ram_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .fill_start(fill_start), .fill_line(fill_line), .fill_valid(fill_valid),
      .fill_ready(fill_ready), .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
      .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1)
   );

   // SRAM macro: captures pins on posedge, performs the access on the following negedge.
   always @(posedge clk) begin
      m_csb0 <= csb0; m_web0 <= web0; m_wm0 <= wmask0; m_a0 <= addr0; m_d0 <= din0;
      m_csb1 <= csb1; m_web1 <= web1; m_wm1 <= wmask1; m_a1 <= addr1; m_d1 <= din1;
   end

   always @(negedge clk) begin
      if (!m_csb0) begin
         if (!m_web0) begin
            for (int i = 0; i < 8; i++) if (m_wm0[i]) sram[m_a0][4*i +: 4] <= m_d0[4*i +: 4];
         end else begin
            dout0 <= sram[m_a0];
         end
      end
      if (!m_csb1 && !m_web1) begin
         for (int i = 0; i < 8; i++) if (m_wm1[i]) sram[m_a1][4*i +: 4] <= m_d1[4*i +: 4];
      end
   end

   function automatic void ref_store(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic we, input logic [3:0] be, input logic [6:0] addr, input logic [31:0] data);
      bit ok = 0;
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = data;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = (req_ready === 1'b1);
         tick();
      end
      req_valid = 1'b0;
      if (!ok) begin
         compared++; mismatched++;
         $display("FAIL req_accept_timeout addr=%h ready=%b required 1", addr, req_ready);
      end
   endtask

   task automatic get_rsp(output logic [31:0] d, output bit ok);
      ok = 0;
      d  = 32'h0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (rsp_valid === 1'b1) begin
            d = rsp_rdata; ok = 1;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({csb0, web0, csb1, web1, rsp_valid, fill_busy, fill_done, fill_ready} !== 8'b1111_0000) begin
         mismatched++;
         $display("FAIL reset_ctrl got=%b required 11110000",
                  {csb0, web0, csb1, web1, rsp_valid, fill_busy, fill_done, fill_ready});
      end
      compared++;
      if ({wmask0, wmask1, addr0, addr1, din0, din1} !== 94'h0) begin
         mismatched++;
         $display("FAIL reset_data wm0=%h wm1=%h a0=%h a1=%h d0=%h d1=%h required all 0",
                  wmask0, wmask1, addr0, addr1, din0, din1);
      end
      rst_n = 1'b1;
      tick(); tick();
      compared++;
      if ({csb0, csb1, rsp_valid, fill_busy, req_ready} !== 5'b11001) begin
         mismatched++;
         $display("FAIL reset_release got=%b required 11001", {csb0, csb1, rsp_valid, fill_busy, req_ready});
      end
   endtask

   task automatic test_store_load();
      logic v0, v1, v2;
      logic [31:0] d;
      rsp_ready = 1'b0;
      send_req(1'b1, 4'hF, 7'h05, 32'hDEADBEEF);
      ref_store(7'h05, 4'hF, 32'hDEADBEEF);
      send_req(1'b0, 4'h0, 7'h05, 32'h0);
      compared++;
      if ({csb0, web0, addr0} !== {1'b0, 1'b1, 7'h05}) begin
         mismatched++;
         $display("FAIL load_pins csb0=%b web0=%b addr0=%h required 0 1 05", csb0, web0, addr0);
      end
      v0 = rsp_valid; tick();
      v1 = rsp_valid; tick();
      v2 = rsp_valid; d = rsp_rdata;
      compared++;
      if ({v0, v1, v2} !== 3'b001) begin
         mismatched++;
         $display("FAIL load_latency valid_seq=%b required 001", {v0, v1, v2});
      end
      compared++;
      if (d !== 32'hDEADBEEF) begin
         mismatched++;
         $display("FAIL load_data got=%h required deadbeef", d);
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_partial_store();
      logic [31:0] d;
      bit ok;
      send_req(1'b1, 4'hF, 7'h20, 32'h11223344);
      send_req(1'b1, 4'b0010, 7'h20, 32'h0000AB00);
      compared++;
      if ({csb0, web0, wmask0} !== {1'b0, 1'b0, 8'h0C}) begin
         mismatched++;
         $display("FAIL partial_wmask csb0=%b web0=%b wmask0=%h required 0 0 0c", csb0, web0, wmask0);
      end
      send_req(1'b1, 4'h0, 7'h20, 32'hFFFFFFFF);
      compared++;
      if (csb0 !== 1'b1) begin
         mismatched++;
         $display("FAIL be0_no_access csb0=%b required 1", csb0);
      end
      ref_store(7'h20, 4'hF, 32'h11223344);
      ref_store(7'h20, 4'b0010, 32'h0000AB00);
      send_req(1'b0, 4'h0, 7'h20, 32'h0);
      get_rsp(d, ok);
      compared++;
      if (!ok || d !== 32'h1122AB44) begin
         mismatched++;
         $display("FAIL partial_data got=%h valid=%b required 1122ab44", d, ok);
      end
   endtask

   task automatic test_credit();
      logic [4:0]  r;
      logic [31:0] d;
      bit ok;
      rsp_ready = 1'b0;
      send_req(1'b1, 4'hF, 7'h30, 32'hA1A1A1A1);
      send_req(1'b1, 4'hF, 7'h31, 32'hB2B2B2B2);
      send_req(1'b1, 4'hF, 7'h32, 32'hC3C3C3C3);
      ref_store(7'h30, 4'hF, 32'hA1A1A1A1);
      ref_store(7'h31, 4'hF, 32'hB2B2B2B2);
      ref_store(7'h32, 4'hF, 32'hC3C3C3C3);
      req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0;
      for (int i = 0; i < 5; i++) begin
         req_addr = (i < 2) ? 7'(8'h30 + i) : 7'h32;
         #1;
         r[4-i] = req_ready;
         tick();
      end
      compared++;
      if (r !== 5'b11000) begin
         mismatched++;
         $display("FAIL credit_ready_seq got=%b required 11000", r);
      end
      compared++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA1A1A1A1}) begin
         mismatched++;
         $display("FAIL credit_first valid=%b data=%h required 1 a1a1a1a1", rsp_valid, rsp_rdata);
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      #1;
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL credit_release ready=%b required 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      get_rsp(d, ok);
      compared++;
      if (!ok || d !== 32'hB2B2B2B2) begin
         mismatched++;
         $display("FAIL credit_order2 got=%h valid=%b required b2b2b2b2", d, ok);
      end
      get_rsp(d, ok);
      compared++;
      if (!ok || d !== 32'hC3C3C3C3) begin
         mismatched++;
         $display("FAIL credit_order3 got=%h valid=%b required c3c3c3c3", d, ok);
      end
   endtask

   task automatic test_fill_conflict();
      int done_cnt = 0;
      logic r13, r40;
      logic [31:0] d;
      bit ok;
      send_req(1'b1, 4'hF, 7'd40, 32'hCAFE0040);
      ref_store(7'd40, 4'hF, 32'hCAFE0040);
      rsp_ready = 1'b0;
      fill_line = 5'd3; fill_start = 1'b1; tick(); fill_start = 1'b0;
      compared++;
      if ({fill_busy, fill_ready, fill_done} !== 3'b110) begin
         mismatched++;
         $display("FAIL fill_enter busy/ready/done=%b required 110", {fill_busy, fill_ready, fill_done});
      end
      for (int i = 0; i < 4; i++) begin
         fill_valid = 1'b0;
         for (int g = 0; g < (i % 2) + 1; g++) begin
            tick();
            if (fill_done) done_cnt++;
         end
         if (i == 1) begin
            fill_start = 1'b1; fill_line = 5'd7;
            req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 7'd13;
            #1; r13 = req_ready;
            req_addr = 7'd40;
            #1; r40 = req_ready;
            compared++;
            if ({r13, r40} !== 2'b01) begin
               mismatched++;
               $display("FAIL conflict_ready addr13=%b addr40=%b required 0 1", r13, r40);
            end
            tick();
            if (fill_done) done_cnt++;
            req_valid = 1'b0; fill_start = 1'b0; fill_line = 5'd3;
         end
         fill_valid = 1'b1; fill_data = 32'(i + 1);
         tick();
         fill_valid = 1'b0;
         if (fill_done) done_cnt++;
         compared++;
         if ({csb1, web1, wmask1, addr1, din1} !== {1'b0, 1'b0, 8'hFF, 7'(12 + i), 32'(i + 1)}) begin
            mismatched++;
            $display("FAIL fill_beat%0d csb1=%b web1=%b wmask1=%h addr1=%0d din1=%h required 0 0 ff %0d %h",
                     i, csb1, web1, wmask1, addr1, din1, 12 + i, i + 1);
         end
         ref_mem[7'(12 + i)] = 32'(i + 1);
      end
      compared++;
      if ({fill_done, fill_busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL fill_done_state done/busy=%b required 11", {fill_done, fill_busy});
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (fill_done) done_cnt++;
      end
      compared++;
      if ({fill_done, fill_busy, done_cnt} !== {2'b00, 32'd1}) begin
         mismatched++;
         $display("FAIL fill_done_pulse done=%b busy=%b pulses=%0d required 0 0 1", fill_done, fill_busy, done_cnt);
      end
      get_rsp(d, ok);
      compared++;
      if (!ok || d !== 32'hCAFE0040) begin
         mismatched++;
         $display("FAIL parallel_load40 got=%h valid=%b required cafe0040", d, ok);
      end
      for (int i = 0; i < 4; i++) begin
         send_req(1'b0, 4'h0, 7'(12 + i), 32'h0);
         get_rsp(d, ok);
         compared++;
         if (!ok || d !== 32'(i + 1)) begin
            mismatched++;
            $display("FAIL fill_readback%0d got=%h valid=%b required %h", i, d, ok, i + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      rsp_ready = 1'b0;
      fill_line = 5'd9; fill_start = 1'b1; tick(); fill_start = 1'b0;
      fill_valid = 1'b1; fill_data = $urandom; tick();
      fill_data = $urandom; tick();
      fill_valid = 1'b0;
      send_req(1'b0, 4'h0, 7'h41, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if ({csb0, web0, csb1, web1, rsp_valid, fill_busy, fill_done, fill_ready} !== 8'b1111_0000) begin
         mismatched++;
         $display("FAIL midreset_ctrl got=%b required 11110000",
                  {csb0, web0, csb1, web1, rsp_valid, fill_busy, fill_done, fill_ready});
      end
      compared++;
      if ({wmask0, wmask1, addr0, addr1, din0, din1} !== 94'h0) begin
         mismatched++;
         $display("FAIL midreset_data wm0=%h wm1=%h a0=%h a1=%h d0=%h d1=%h required all 0",
                  wmask0, wmask1, addr0, addr1, din0, din1);
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         seen = seen | rsp_valid | fill_busy | fill_done;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_quiet activity=%b required 0", seen);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_q[$];
      int ops = 0;
      bit exp_ready, fire;
      logic [31:0] d;
      for (int a = 0; a < 128; a++) begin
         d = $urandom;
         send_req(1'b1, 4'hF, 7'(a), d);
         ref_store(7'(a), 4'hF, d);
      end
      req_valid = 1'b0;
      for (int c = 0; c < 6000 && !(ops >= 300 && exp_q.size() == 0); c++) begin
         if (!req_valid && ops < 300) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            req_addr  = 7'($urandom);
            req_wdata = $urandom;
            req_be    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         fire = 0;
         if (req_valid) begin
            exp_ready = req_we || (exp_q.size() < 2);
            compared++;
            if (req_ready !== exp_ready) begin
               mismatched++;
               $display("FAIL rand_req_ready we=%b got=%b required %b outstanding=%0d",
                        req_we, req_ready, exp_ready, exp_q.size());
            end
         end
         if (rsp_valid && (rsp_ready || exp_q.size() == 0)) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL rand_unexpected_rsp data=%h required no response", rsp_rdata);
            end else begin
               if (rsp_rdata !== exp_q[0]) begin
                  mismatched++;
                  $display("FAIL rand_rsp_data got=%h required %h", rsp_rdata, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         if (req_valid && req_ready) begin
            if (req_we) ref_store(req_addr, req_be, req_wdata);
            else        exp_q.push_back(ref_mem[req_addr]);
            ops++;
            fire = 1;
         end
         tick();
         if (fire) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      compared++;
      if (!(ops >= 300 && exp_q.size() == 0)) begin
         mismatched++;
         $display("FAIL rand_incomplete ops=%0d outstanding=%0d required 300 0", ops, exp_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 7'h0; req_wdata = 32'h0;
      rsp_ready = 1'b0;
      fill_start = 1'b0; fill_line = 5'h0; fill_valid = 1'b0; fill_data = 32'h0;
      test_reset();
      test_store_load();
      test_partial_store();
      test_credit();
      test_fill_conflict();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
